// File: rtl/cell_ram_loader.sv
// -----------------------------------------------------------------------------
// cell_ram_loader
//
// Avalon-MM slave that loads the configuration of one cell row. Each PORT_WIDTH
// word written by the HPS bridge is one slot, which holds PORT_WIDTH/4 cells
// with a 4-bit LUT per cell. The block keeps a shadow copy of the whole row
// config. That copy drives set_ram and is also the source for slot readback.
// Each accepted slot write pulses that slot's we_ram bit for WE_CYCLES cycles.
// A CTRL write with bit0 set re-pulses every slot with the current shadow.
//
// Address map (word addresses):
//   0 .. SLOTS-1  slot s, read/write
//   SLOTS         CTRL, write-only; bit0 = 1 reloads all slots
//   SLOTS+1       STATUS, read-only; {wr_count[PORT_WIDTH-2:0], busy}
//
// Ports:
//   clk              clock
//   rst              asynchronous active-high reset
//   avs_address      Avalon word address
//   avs_write        write request
//   avs_writedata    write data
//   avs_read         read request (never stalled)
//   avs_readdata     read data, registered, valid the cycle after avs_read
//   avs_waitrequest  high while a we_ram pulse is in progress
//   we_ram           per-slot write enables to the cell row
//   set_ram          row config data (the shadow register)
//   busy             copy of avs_waitrequest for status/debug
// -----------------------------------------------------------------------------
module cell_ram_loader #(
    parameter int DIMX       = 64,
    parameter int PORT_WIDTH = 32,
    parameter int SLOTS      = DIMX * 4 / PORT_WIDTH,
    parameter int WE_CYCLES  = 1,
    parameter int ADDR_W     = $clog2(SLOTS + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_write,
    input  logic [PORT_WIDTH-1:0] avs_writedata,
    input  logic                  avs_read,
    output logic [PORT_WIDTH-1:0] avs_readdata,
    output logic                  avs_waitrequest,
    output logic [SLOTS-1:0]      we_ram,
    output logic [DIMX*4-1:0]     set_ram,
    output logic                  busy
);

    localparam int CFG_W = DIMX * 4;
    localparam int WC_W  = PORT_WIDTH - 1;
    // The down-counter only needs to reach WE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(SLOTS);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(SLOTS + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(WE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic [SLOTS-1:0]      we_r;
    logic [SLOTS-1:0]      we_s;
    logic [CFG_W-1:0]      shadow_r;
    logic [CFG_W-1:0]      shadow_s;
    logic [WC_W-1:0]       wr_count_r;
    logic [WC_W-1:0]       wr_count_s;
    logic [PORT_WIDTH-1:0] readdata_r;
    logic [PORT_WIDTH-1:0] readdata_s;
    logic                  busy_s;
    logic [SLOTS-1:0]      slot_sel_s;

    // One-hot slot decode. It is all-zero for CTRL, STATUS and unmapped addresses.
    function automatic logic [SLOTS-1:0] slot_decode(input logic [ADDR_W-1:0] addr);
        logic [SLOTS-1:0] sel;
        sel = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (addr == ADDR_W'(s)) begin
                sel[s] = 1'b1;
            end else begin
                sel[s] = 1'b0;
            end
        end
        return sel;
    endfunction

    // Read mux: shadow slot, live STATUS, or zero for CTRL/unmapped.
    function automatic logic [PORT_WIDTH-1:0] read_word(
        input logic [ADDR_W-1:0] addr,
        input logic [CFG_W-1:0]  shadow,
        input logic [WC_W-1:0]   count,
        input logic              bsy
    );
        logic [PORT_WIDTH-1:0] word;
        word = '0;
        if (addr == STATUS_ADDR) begin
            word = {count, bsy};
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (addr == ADDR_W'(s)) begin
                    word = shadow[s*PORT_WIDTH +: PORT_WIDTH];
                end else begin
                    word = word;
                end
            end
        end
        return word;
    endfunction

    assign busy_s     = (state_r == ST_PULSE);
    assign slot_sel_s = slot_decode(avs_address);

    // Next-state logic for the pulse FSM, shadow, enables and completion counter.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        we_s       = we_r;
        shadow_s   = shadow_r;
        wr_count_s = wr_count_r;
        case (state_r)
            ST_IDLE: begin
                we_s = '0;
                // waitrequest is low in IDLE, so any avs_write here is accepted.
                if (avs_write && (slot_sel_s != '0)) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (slot_sel_s[s]) begin
                            shadow_s[s*PORT_WIDTH +: PORT_WIDTH] = avs_writedata;
                        end else begin
                            shadow_s[s*PORT_WIDTH +: PORT_WIDTH] = shadow_r[s*PORT_WIDTH +: PORT_WIDTH];
                        end
                    end
                    we_s    = slot_sel_s;
                    cnt_s   = CNT_LOAD;
                    state_s = ST_PULSE;
                end else if (avs_write && (avs_address == CTRL_ADDR) && avs_writedata[0]) begin
                    // Reload: re-pulse every slot with the unchanged shadow.
                    we_s    = '1;
                    cnt_s   = CNT_LOAD;
                    state_s = ST_PULSE;
                end else begin
                    // CTRL with bit0=0, STATUS or unmapped writes are swallowed.
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == '0) begin
                    we_s       = '0;
                    wr_count_s = wr_count_r + WC_W'(1);
                    state_s    = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                we_s    = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pulse FSM, shadow, enables and completion counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            we_r       <= '0;
            shadow_r   <= '0;
            wr_count_r <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            we_r       <= we_s;
            shadow_r   <= shadow_s;
            wr_count_r <= wr_count_s;
        end
    end

    // Read data select. It holds the last value when no read is issued, and
    // the mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        readdata_s = readdata_r;
        if (avs_read) begin
            readdata_s = read_word(avs_address, shadow_r, wr_count_r, busy_s);
        end else begin
            readdata_s = readdata_r;
        end
    end

    // Read data register, fixed latency of one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_r <= '0;
        end else begin
            readdata_r <= readdata_s;
        end
    end

    assign avs_readdata    = readdata_r;
    assign avs_waitrequest = busy_s;
    assign busy            = busy_s;
    assign we_ram          = we_r;
    assign set_ram         = shadow_r;

endmodule
